// File: rtl/generator_seq_if.sv
// Handshake and operand bundle between a latent-vector source and generator_seq.
// Weights and biases travel with the handshake signals and are not latched by the block.
interface generator_seq_if #(
    parameter int WIDTH    = 32,
    parameter int N_LATENT = 2,
    parameter int N_HIDDEN = 3,
    parameter int N_OUTPUT = 9
);
    logic                                in_valid;
    logic                                in_ready;
    logic [WIDTH-1:0]                    z_1;
    logic [WIDTH-1:0]                    z_2;
    logic [N_LATENT*N_HIDDEN*WIDTH-1:0]  w_L1;
    logic [N_HIDDEN*N_OUTPUT*WIDTH-1:0]  w_L2;
    logic [N_HIDDEN*WIDTH-1:0]           b_L1;
    logic [N_OUTPUT*WIDTH-1:0]           b_L2;
    logic                                out_valid;
    logic                                out_ready;
    logic [N_OUTPUT*WIDTH-1:0]           y;

    modport master (
        output in_valid, z_1, z_2, w_L1, w_L2, b_L1, b_L2, out_ready,
        input  in_ready, out_valid, y
    );

    modport slave (
        input  in_valid, z_1, z_2, w_L1, w_L2, b_L1, b_L2, out_ready,
        output in_ready, out_valid, y
    );
endinterface

// File: rtl/generator_seq.sv
// Time-multiplexed GAN generator: 2 latent -> 3 hidden (ReLU) -> 9 outputs clamped to [0, 1.0],
// computed one multiply-accumulate per clock by a single FSM.
module generator_seq #(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 16,
    parameter int N_LATENT  = 2,
    parameter int N_HIDDEN  = 3,
    parameter int N_OUTPUT  = 9,
    parameter int GUARD     = 8
) (
    input  logic           clk,
    input  logic           rst,
    generator_seq_if.slave bus
);
    localparam int ACC_W  = WIDTH + GUARD;
    localparam int PROD_W = 2 * WIDTH;
    localparam int CNT_W  = $clog2(N_LATENT + N_HIDDEN + N_OUTPUT + 1);

    localparam logic [CNT_W-1:0] K_L1_LAST = CNT_W'(N_LATENT - 1);
    localparam logic [CNT_W-1:0] K_L2_LAST = CNT_W'(N_HIDDEN - 1);
    localparam logic [CNT_W-1:0] I_L1_LAST = CNT_W'(N_HIDDEN - 1);
    localparam logic [CNT_W-1:0] J_L2_LAST = CNT_W'(N_OUTPUT - 1);
    localparam logic signed [WIDTH-1:0] ONE_FX =
        {{(WIDTH-1-FRAC_BITS){1'b0}}, 1'b1, {FRAC_BITS{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_L1_MAC = 3'd1,
        S_L1_WR  = 3'd2,
        S_L2_MAC = 3'd3,
        S_L2_WR  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                      r_state;
    logic [CNT_W-1:0]            r_i;
    logic [CNT_W-1:0]            r_k;
    logic signed [ACC_W-1:0]     r_acc;
    logic [N_LATENT*WIDTH-1:0]   r_z;
    logic [N_HIDDEN*WIDTH-1:0]   r_hidden;
    logic [N_OUTPUT*WIDTH-1:0]   r_y;
    logic                        r_in_ready;
    logic                        r_out_valid;

    logic signed [WIDTH-1:0]     w_op_a;
    logic signed [WIDTH-1:0]     w_op_b;
    logic signed [PROD_W-1:0]    w_prod;
    logic signed [ACC_W-1:0]     w_acc_sum;
    logic signed [ACC_W-1:0]     w_next_bias;
    logic signed [WIDTH-1:0]     w_sat;
    logic signed [WIDTH-1:0]     w_relu;
    logic signed [WIDTH-1:0]     w_clamp;

    function automatic logic signed [ACC_W-1:0] sext(input logic [WIDTH-1:0] v);
        return ACC_W'($signed(v));
    endfunction

    // Values whose guard bits are not pure sign extension are outside the WIDTH range.
    function automatic logic signed [WIDTH-1:0] sat_word(input logic signed [ACC_W-1:0] a);
        logic [ACC_W-WIDTH:0] top;
        top = a[ACC_W-1:WIDTH-1];
        if ((top == '0) || (top == '1)) begin
            return a[WIDTH-1:0];
        end else if (a[ACC_W-1]) begin
            return {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            return {1'b0, {(WIDTH-1){1'b1}}};
        end
    endfunction

    // Operand selection and the next bias to preload, by state and counters.
    always_comb begin
        w_op_a      = '0;
        w_op_b      = '0;
        w_next_bias = '0;
        case (r_state)
            S_L1_MAC: begin
                w_op_a = r_z[int'(r_k)*WIDTH +: WIDTH];
                w_op_b = bus.w_L1[(N_LATENT*int'(r_i) + int'(r_k))*WIDTH +: WIDTH];
            end
            S_L2_MAC: begin
                w_op_a = r_hidden[int'(r_k)*WIDTH +: WIDTH];
                w_op_b = bus.w_L2[(N_HIDDEN*int'(r_i) + int'(r_k))*WIDTH +: WIDTH];
            end
            S_L1_WR: begin
                if (r_i == I_L1_LAST) begin
                    w_next_bias = sext(bus.b_L2[0 +: WIDTH]);
                end else begin
                    w_next_bias = sext(bus.b_L1[(int'(r_i)+1)*WIDTH +: WIDTH]);
                end
            end
            S_L2_WR: begin
                if (r_i == J_L2_LAST) begin
                    w_next_bias = '0;
                end else begin
                    w_next_bias = sext(bus.b_L2[(int'(r_i)+1)*WIDTH +: WIDTH]);
                end
            end
            default: begin
                w_op_a      = '0;
                w_op_b      = '0;
                w_next_bias = '0;
            end
        endcase
    end

    // Shared MAC: full product, floor shift to the fixed-point scale, wrap into the accumulator.
    always_comb begin
        w_prod    = w_op_a * w_op_b;
        w_acc_sum = r_acc + ACC_W'(w_prod >>> FRAC_BITS);
    end

    // Activations applied to the saturated accumulator at write time.
    always_comb begin
        w_sat = sat_word(r_acc);
        if (w_sat[WIDTH-1]) begin
            w_relu  = '0;
            w_clamp = '0;
        end else if (w_sat > ONE_FX) begin
            w_relu  = w_sat;
            w_clamp = ONE_FX;
        end else begin
            w_relu  = w_sat;
            w_clamp = w_sat;
        end
    end

    // Sequencer FSM with registered handshake outputs and datapath state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_i         <= '0;
            r_k         <= '0;
            r_acc       <= '0;
            r_z         <= '0;
            r_hidden    <= '0;
            r_y         <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_z        <= {bus.z_2, bus.z_1};
                        r_acc      <= sext(bus.b_L1[0 +: WIDTH]);
                        r_i        <= '0;
                        r_k        <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_L1_MAC;
                    end
                end
                S_L1_MAC: begin
                    r_acc <= w_acc_sum;
                    if (r_k == K_L1_LAST) begin
                        r_k     <= '0;
                        r_state <= S_L1_WR;
                    end else begin
                        r_k <= r_k + CNT_W'(1);
                    end
                end
                S_L1_WR: begin
                    r_hidden[int'(r_i)*WIDTH +: WIDTH] <= w_relu;
                    r_acc <= w_next_bias;
                    if (r_i == I_L1_LAST) begin
                        r_i     <= '0;
                        r_state <= S_L2_MAC;
                    end else begin
                        r_i     <= r_i + CNT_W'(1);
                        r_state <= S_L1_MAC;
                    end
                end
                S_L2_MAC: begin
                    r_acc <= w_acc_sum;
                    if (r_k == K_L2_LAST) begin
                        r_k     <= '0;
                        r_state <= S_L2_WR;
                    end else begin
                        r_k <= r_k + CNT_W'(1);
                    end
                end
                S_L2_WR: begin
                    r_y[int'(r_i)*WIDTH +: WIDTH] <= w_clamp;
                    r_acc <= w_next_bias;
                    if (r_i == J_L2_LAST) begin
                        r_i         <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_i     <= r_i + CNT_W'(1);
                        r_state <= S_L2_MAC;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.y         = r_y;
endmodule

// File: tb/tb_generator_seq.sv
// Directed bench for generator_seq: latency, ReLU, output clamp, saturation, backpressure, mid-run reset.
module tb_generator_seq;
    localparam int W  = 32;
    localparam int NL = 2;
    localparam int NH = 3;
    localparam int NO = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    generator_seq_if #(.WIDTH(W), .N_LATENT(NL), .N_HIDDEN(NH), .N_OUTPUT(NO)) bus_if ();

    generator_seq #(
        .WIDTH(W), .FRAC_BITS(16), .N_LATENT(NL), .N_HIDDEN(NH), .N_OUTPUT(NO), .GUARD(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        bus_if.z_1       = 32'h0;
        bus_if.z_2       = 32'h0;
        bus_if.w_L1      = '0;
        bus_if.w_L2      = '0;
        bus_if.b_L1      = '0;
        bus_if.b_L2      = '0;
    endtask

    // Accepts one latent vector and counts edges from the accept edge until out_valid.
    task automatic start_and_wait(output int edges);
        bus_if.in_valid = 1'b1;
        tick();
        bus_if.in_valid = 1'b0;
        edges = 0;
        do begin
            tick();
            edges++;
        end while (!bus_if.out_valid && edges < 200);
    endtask

    task automatic release_sample();
        bus_if.out_ready = 1'b1;
        tick();
        bus_if.out_ready = 1'b0;
    endtask

    task automatic setup_bias_pass();
        clear_inputs();
        for (int j = 0; j < NO; j++) bus_if.b_L2[j*W +: W] = 32'h0000_8000;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (bus_if.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b want 1", bus_if.in_ready);
        end
        checks++;
        if (bus_if.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b want 0", bus_if.out_valid);
        end
        checks++;
        if (bus_if.y !== '0) begin
            errors++; $display("FAIL reset_y: got %h want 0", bus_if.y);
        end
    endtask

    task automatic test_bias_pass();
        int edges;
        setup_bias_pass();
        start_and_wait(edges);
        checks++;
        if (edges !== 45) begin
            errors++; $display("FAIL bias_latency: got %0d edges want 45", edges);
        end
        for (int j = 0; j < NO; j++) begin
            checks++;
            if (bus_if.y[j*W +: W] !== 32'h0000_8000) begin
                errors++; $display("FAIL bias_y%0d: got %h want 00008000", j, bus_if.y[j*W +: W]);
            end
        end
        release_sample();
    endtask

    task automatic test_relu();
        int edges;
        logic [W-1:0] want;
        for (int pass = 0; pass < 2; pass++) begin
            clear_inputs();
            bus_if.z_1 = (pass == 0) ? 32'h0001_0000 : 32'hFFFF_0000;
            bus_if.w_L1[0 +: W] = 32'h0001_0000;
            for (int j = 0; j < NO; j++) bus_if.w_L2[(3*j)*W +: W] = 32'h0000_4000;
            want = (pass == 0) ? 32'h0000_4000 : 32'h0;
            start_and_wait(edges);
            checks++;
            if (edges !== 45) begin
                errors++; $display("FAIL relu_latency%0d: got %0d edges want 45", pass, edges);
            end
            for (int j = 0; j < NO; j++) begin
                checks++;
                if (bus_if.y[j*W +: W] !== want) begin
                    errors++; $display("FAIL relu%0d_y%0d: got %h want %h", pass, j, bus_if.y[j*W +: W], want);
                end
            end
            release_sample();
        end
    endtask

    // out_ready held high throughout: it must not disturb the computation.
    task automatic test_clamp();
        int edges;
        logic [W-1:0] want;
        clear_inputs();
        for (int j = 0; j < NO; j++)
            bus_if.b_L2[j*W +: W] = (j % 2 == 0) ? 32'h0003_0000 : 32'hFFFE_0000;
        bus_if.out_ready = 1'b1;
        start_and_wait(edges);
        checks++;
        if (edges !== 45) begin
            errors++; $display("FAIL clamp_latency: got %0d edges want 45", edges);
        end
        for (int j = 0; j < NO; j++) begin
            want = (j % 2 == 0) ? 32'h0001_0000 : 32'h0;
            checks++;
            if (bus_if.y[j*W +: W] !== want) begin
                errors++; $display("FAIL clamp_y%0d: got %h want %h", j, bus_if.y[j*W +: W], want);
            end
        end
        tick();
        bus_if.out_ready = 1'b0;
        checks++;
        if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b1) begin
            errors++; $display("FAIL clamp_release: got valid=%b ready=%b want 0/1",
                               bus_if.out_valid, bus_if.in_ready);
        end
    endtask

    task automatic test_saturation();
        int edges;
        clear_inputs();
        bus_if.z_1 = 32'h7FFF_FFFF;
        bus_if.z_2 = 32'h7FFF_FFFF;
        for (int i = 0; i < NL*NH; i++) bus_if.w_L1[i*W +: W] = 32'h0001_0000;
        for (int i = 0; i < NH; i++) bus_if.b_L1[i*W +: W] = 32'h7FFF_FFFF;
        for (int j = 0; j < NO; j++) bus_if.w_L2[(3*j)*W +: W] = 32'h0000_0001;
        start_and_wait(edges);
        checks++;
        if (edges !== 45) begin
            errors++; $display("FAIL sat_latency: got %0d edges want 45", edges);
        end
        for (int j = 0; j < NO; j++) begin
            checks++;
            if (bus_if.y[j*W +: W] !== 32'h0000_7FFF) begin
                errors++; $display("FAIL sat_y%0d: got %h want 00007fff", j, bus_if.y[j*W +: W]);
            end
        end
        release_sample();
    endtask

    task automatic test_backpressure();
        int edges;
        logic [NO*W-1:0] held;
        setup_bias_pass();
        start_and_wait(edges);
        checks++;
        if (edges !== 45) begin
            errors++; $display("FAIL bp_latency: got %0d edges want 45", edges);
        end
        held = bus_if.y;
        for (int c = 0; c < 10; c++) begin
            bus_if.in_valid = (c % 3 == 0);
            bus_if.b_L2[0 +: W] = 32'h0000_1000;
            tick();
            checks++;
            if (bus_if.out_valid !== 1'b1 || bus_if.in_ready !== 1'b0 || bus_if.y !== held) begin
                errors++; $display("FAIL bp_hold%0d: got valid=%b ready=%b y0=%h want 1/0/00008000",
                                   c, bus_if.out_valid, bus_if.in_ready, bus_if.y[0 +: W]);
            end
        end
        bus_if.in_valid = 1'b0;
        release_sample();
        checks++;
        if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release: got valid=%b ready=%b want 0/1",
                               bus_if.out_valid, bus_if.in_ready);
        end
        tick();
        checks++;
        if (bus_if.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_idle: got ready=%b want 1", bus_if.in_ready);
        end
    endtask

    task automatic test_mid_reset();
        int edges;
        setup_bias_pass();
        bus_if.in_valid = 1'b1;
        tick();
        bus_if.in_valid = 1'b0;
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b1 || bus_if.y !== '0) begin
            errors++; $display("FAIL midrst_state: got valid=%b ready=%b y0=%h want 0/1/0",
                               bus_if.out_valid, bus_if.in_ready, bus_if.y[0 +: W]);
        end
        start_and_wait(edges);
        checks++;
        if (edges !== 45) begin
            errors++; $display("FAIL midrst_latency: got %0d edges want 45", edges);
        end
        for (int j = 0; j < NO; j++) begin
            checks++;
            if (bus_if.y[j*W +: W] !== 32'h0000_8000) begin
                errors++; $display("FAIL midrst_y%0d: got %h want 00008000", j, bus_if.y[j*W +: W]);
            end
        end
        release_sample();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_bias_pass();
        test_relu();
        test_clamp();
        test_saturation();
        test_backpressure();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
